exec_issue_ctrl: RTL and testbench

Initiator side of the execution-controller interface. Accepts decoded instructions (opcode plus register addresses) over a valid/ready handshake. Reads operands from an internal register file and drives the execution controller's enable/opcode/operand/destination lines. Waits for its ready, then writes the result back to the register file. Sits between instruction decode and the execution controller; owns the architectural register file.

---
 rtl/exec_issue_ctrl_pkg.sv | 15 +
 rtl/exec_regfile.sv | 37 +++
 rtl/exec_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_exec_issue_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_issue_ctrl_pkg.sv
// Shared opcode constants and issue-FSM state encoding for the execution-controller initiator.
package exec_issue_ctrl_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/exec_regfile.sv
// Architectural register file: SIZE x WIDTH, cleared on reset, one write port, three async reads.
// Writes land at the clock edge; reads are combinational, so no backpressure applies.
module exec_regfile #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 64,
    parameter int AW    = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr1_i,
    output logic [WIDTH-1:0] rdata1_o,
    input  logic [AW-1:0]    raddr2_i,
    output logic [WIDTH-1:0] rdata2_o,
    input  logic [AW-1:0]    raddr3_i,
    output logic [WIDTH-1:0] rdata3_o
);

    logic [WIDTH-1:0] mem_q [SIZE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];
    assign rdata3_o = mem_q[raddr3_i];

endmodule

// File: rtl/exec_issue_ctrl.sv
// Issues decoded instructions to the execution controller and writes results back to the regfile.
// Handshake to exec_enable is 2 edges, to done >= 3 cycles; instr_ready is low while busy.
module exec_issue_ctrl
    import exec_issue_ctrl_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int SIZE    = 64,
    parameter  int TIMEOUT = 255,
    localparam int AW      = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [1:0]       instr_op,
    input  logic [AW-1:0]    instr_dst,
    input  logic [AW-1:0]    instr_src1,
    input  logic [AW-1:0]    instr_src2,
    output logic             exec_enable,
    output logic [1:0]       exec_opcode,
    output logic [WIDTH-1:0] exec_src1,
    output logic [WIDTH-1:0] exec_src2,
    output logic [AW-1:0]    exec_dst_addr,
    input  logic             exec_ready,
    input  logic [WIDTH-1:0] exec_result,
    input  logic             init_we,
    input  logic [AW-1:0]    init_addr,
    input  logic [WIDTH-1:0] init_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic             done,
    output logic             timeout_err,
    output logic             busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [AW-1:0]    dst_q, dst_d, src1a_q, src1a_d, src2a_q, src2a_d;
    logic             en_q, en_d;
    logic [1:0]       opc_q, opc_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [AW-1:0]    daddr_q, daddr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;

    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata, rf_rd1, rf_rd2;

    exec_regfile #(.WIDTH(WIDTH), .SIZE(SIZE), .AW(AW)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (rf_we),
        .waddr_i  (rf_waddr),
        .wdata_i  (rf_wdata),
        .raddr1_i (src1a_q),
        .rdata1_o (rf_rd1),
        .raddr2_i (src2a_q),
        .rdata2_o (rf_rd2),
        .raddr3_i (dbg_addr),
        .rdata3_o (dbg_data)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dst_d    = dst_q;
        src1a_d  = src1a_q;
        src2a_d  = src2a_q;
        en_d     = en_q;
        opc_d    = opc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        daddr_d  = daddr_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        tmo_d    = tmo_q;
        rf_we    = 1'b0;
        rf_waddr = init_addr;
        rf_wdata = init_data;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    op_d    = instr_op;
                    dst_d   = instr_dst;
                    src1a_d = instr_src1;
                    src2a_d = instr_src2;
                    if (instr_op == OP_NOP) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else if (init_we) begin
                    // Preload only when no instruction is being accepted this cycle.
                    rf_we = 1'b1;
                end
            end
            ST_ISSUE: begin
                opa_d   = rf_rd1;
                opb_d   = rf_rd2;
                opc_d   = op_q;
                daddr_d = dst_q;
                en_d    = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (exec_ready) begin
                    rf_we    = 1'b1;
                    rf_waddr = daddr_q;
                    rf_wdata = exec_result;
                    en_d     = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    en_d    = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            dst_q   <= '0;
            src1a_q <= '0;
            src2a_q <= '0;
            en_q    <= 1'b0;
            opc_q   <= OP_NOP;
            opa_q   <= '0;
            opb_q   <= '0;
            daddr_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src1a_q <= src1a_d;
            src2a_q <= src2a_d;
            en_q    <= en_d;
            opc_q   <= opc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            daddr_q <= daddr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    assign instr_ready   = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign exec_enable   = en_q;
    assign exec_opcode   = opc_q;
    assign exec_src1     = opa_q;
    assign exec_src2     = opb_q;
    assign exec_dst_addr = daddr_q;
    assign done          = done_q;
    assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Randomized bench for exec_issue_ctrl against an array-based register-file and ALU model.
module tb_exec_issue_ctrl;

    localparam int WIDTH = 8;
    localparam int SIZE  = 64;
    localparam int TMO   = 4;
    localparam int AW    = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             instr_valid = 1'b0;
    logic             instr_ready;
    logic [1:0]       instr_op = '0;
    logic [AW-1:0]    instr_dst = '0, instr_src1 = '0, instr_src2 = '0;
    logic             exec_enable;
    logic [1:0]       exec_opcode;
    logic [WIDTH-1:0] exec_src1, exec_src2;
    logic [AW-1:0]    exec_dst_addr;
    logic             exec_ready = 1'b0;
    logic [WIDTH-1:0] exec_result = '0;
    logic             init_we = 1'b0;
    logic [AW-1:0]    init_addr = '0;
    logic [WIDTH-1:0] init_data = '0;
    logic [AW-1:0]    dbg_addr = '0;
    logic [WIDTH-1:0] dbg_data;
    logic             done, timeout_err, busy;

    always #5 clk = ~clk;

    exec_issue_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_dst(instr_dst), .instr_src1(instr_src1), .instr_src2(instr_src2),
        .exec_enable(exec_enable), .exec_opcode(exec_opcode), .exec_src1(exec_src1),
        .exec_src2(exec_src2), .exec_dst_addr(exec_dst_addr),
        .exec_ready(exec_ready), .exec_result(exec_result),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .done(done), .timeout_err(timeout_err), .busy(busy)
    );

    logic [WIDTH-1:0] m_rf [SIZE];
    bit               exp_tmo = 1'b0;
    int               n_chk = 0;
    int               n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] alu(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        case (op)
            2'b01:   return a * b;
            2'b10:   return a + b;
            2'b11:   return a - b;
            default: return a;
        endcase
    endfunction

    task automatic sweep(input string tag);
        for (int i = 0; i < SIZE; i++) begin
            dbg_addr = AW'(i);
            #1;
            check_val($sformatf("%s_r%0d", tag, i), dbg_data, m_rf[i]);
        end
        @(negedge clk);
    endtask

    task automatic preload(input int a, input logic [WIDTH-1:0] d);
        init_we = 1'b1; init_addr = AW'(a); init_data = d;
        @(posedge clk); #1 init_we = 1'b0;
        m_rf[a] = d;
        @(negedge clk);
    endtask

    // A stray exec_ready while idle must not touch anything.
    task automatic idle_cycle();
        exec_ready = 1'b1; exec_result = WIDTH'($urandom);
        @(posedge clk); #1 exec_ready = 1'b0;
        @(negedge clk);
        check_val("idle_done", done, 0);
        check_val("idle_en", exec_enable, 0);
        check_val("idle_busy", busy, 0);
        check_val("idle_tmo", timeout_err, exp_tmo);
    endtask

    // Entered and left at a negedge; lat = WAIT cycle index that sees exec_ready, -1 = never.
    task automatic do_instr(input logic [1:0] op, input int dst, input int s1, input int s2,
                            input int lat, input bit junk);
        logic [WIDTH-1:0] e1, e2, res;
        bit fin;
        instr_valid = 1'b1; instr_op = op;
        instr_dst = AW'(dst); instr_src1 = AW'(s1); instr_src2 = AW'(s2);
        if (junk) begin
            init_we = 1'b1; init_addr = AW'($urandom); init_data = WIDTH'($urandom);
        end
        check_val("instr_ready", instr_ready, 1);
        @(posedge clk); #1 instr_valid = 1'b0;
        if (op == 2'b00) begin
            init_we = 1'b0;
            @(negedge clk);
            check_val("nop_done", done, 1);
            check_val("nop_en", exec_enable, 0);
            check_val("nop_busy", busy, 0);
            return;
        end
        e1 = m_rf[s1]; e2 = m_rf[s2]; res = alu(op, e1, e2);
        @(negedge clk);
        check_val("issue_busy", busy, 1);
        check_val("issue_rdy", instr_ready, 0);
        check_val("issue_en", exec_enable, 0);
        check_val("issue_done", done, 0);
        @(posedge clk); #1;
        fin = 1'b0;
        for (int w = 0; w < TMO && !fin; w++) begin
            @(negedge clk);
            check_val("wait_en", exec_enable, 1);
            check_val("wait_src1", exec_src1, e1);
            check_val("wait_src2", exec_src2, e2);
            check_val("wait_opc", exec_opcode, op);
            check_val("wait_dst", exec_dst_addr, dst);
            check_val("wait_done", done, 0);
            if (w == lat) begin
                exec_ready = 1'b1; exec_result = res;
            end
            @(posedge clk); #1 exec_ready = 1'b0;
            if (w == lat) fin = 1'b1;
        end
        init_we = 1'b0;
        @(negedge clk);
        if (!fin) exp_tmo = 1'b1;
        check_val("end_en", exec_enable, 0);
        check_val("end_done", done, fin);
        check_val("end_busy", busy, 0);
        check_val("end_rdy", instr_ready, 1);
        check_val("end_tmo", timeout_err, exp_tmo);
        if (fin) m_rf[dst] = res;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < SIZE; i++) m_rf[i] = '0;
        repeat (2) @(negedge clk);
        check_val("rst_en", exec_enable, 0);
        check_val("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_rdy", instr_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_tmo", timeout_err, 0);
        check_val("rst_opc", exec_opcode, 0);
        check_val("rst_src1", exec_src1, 0);
        check_val("rst_dst", exec_dst_addr, 0);
        sweep("rst");

        preload(1, 8'd5);
        preload(2, 8'd3);
        do_instr(2'b10, 4, 1, 2, 2, 1'b0);
        check_val("add_r4_model", m_rf[4], 8);
        do_instr(2'b11, 5, 1, 2, 0, 1'b0);
        do_instr(2'b01, 6, 5, 2, 0, 1'b0);
        idle_cycle();
        do_instr(2'b00, 9, 1, 2, 0, 1'b0);
        idle_cycle();
        sweep("dir");

        preload(7, 8'h5A);
        do_instr(2'b10, 7, 1, 2, -1, 1'b0);
        idle_cycle();
        do_instr(2'b10, 8, 1, 2, 1, 1'b0);
        do_instr(2'b01, 10, 4, 4, TMO - 1, 1'b1);
        sweep("tmo");

        for (int k = 0; k < 60; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                preload($urandom_range(0, SIZE - 1), WIDTH'($urandom));
            end else if (r == 2) begin
                idle_cycle();
            end else begin
                do_instr(2'($urandom), $urandom_range(0, SIZE - 1), $urandom_range(0, SIZE - 1),
                         $urandom_range(0, SIZE - 1),
                         ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, TMO - 1),
                         ($urandom_range(0, 3) == 0));
            end
        end
        sweep("rand");

        preload(3, 8'h11);
        instr_valid = 1'b1; instr_op = 2'b10;
        instr_dst = AW'(3); instr_src1 = AW'(3); instr_src2 = AW'(3);
        @(posedge clk); #1 instr_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("prerst_en", exec_enable, 1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < SIZE; i++) m_rf[i] = '0;
        exp_tmo = 1'b0;
        check_val("mid_rst_en", exec_enable, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_rdy", instr_ready, 1);
        check_val("mid_rst_tmo", timeout_err, 0);
        check_val("mid_rst_src1", exec_src1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exec_ready = 1'b1; exec_result = 8'hEE;
        @(posedge clk); #1 exec_ready = 1'b0;
        @(negedge clk);
        check_val("late_rdy_done", done, 0);
        sweep("post_rst");
        preload(3, 8'h21);
        do_instr(2'b10, 3, 3, 3, 1, 1'b0);
        sweep("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
